// File: rtl/nios_system_arb_pkg.sv
// Shared widths and master identifiers for the on-chip memory arbiter.
package nios_system_arb_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef logic [0:0] master_id_t;

   localparam master_id_t M0 = 1'b0;
   localparam master_id_t M1 = 1'b1;
endpackage

// File: rtl/nios_system_rr_arb2.sv
// Two-way round-robin grant: purely combinational, zero latency.
// block suppresses every grant; last_grant is held by the parent.
module nios_system_rr_arb2
   import nios_system_arb_pkg::*;
(
   input  logic [1:0] req,
   input  master_id_t last_grant,
   input  logic       block,
   output logic [1:0] gnt
);
   // On contention the master that did not win last time goes next.
   assign gnt[0] = !block && req[0] && (!req[1] || (last_grant == M1));
   assign gnt[1] = !block && req[1] && (!req[0] || (last_grant == M0));
endmodule

// File: rtl/nios_system_onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters.
// Grant in the request cycle, read data one cycle later; losers and idle masters see waitrequest.
module nios_system_onchip_memory_arbiter
   import nios_system_arb_pkg::*;
#(
   parameter int ADDR_W = nios_system_arb_pkg::ADDR_W,
   parameter int DATA_W = nios_system_arb_pkg::DATA_W,
   parameter int BE_W   = nios_system_arb_pkg::BE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   output logic              mem_reset_req,
   input  logic [DATA_W-1:0] mem_readdata
);
   logic [1:0] req;
   logic [1:0] gnt;
   logic       granted;
   logic       win_read;
   logic       win_write;
   master_id_t winner;
   master_id_t last_grant;
   master_id_t rd_owner;
   logic       rd_pend;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   nios_system_rr_arb2 u_rr_arb2 (
      .req        (req),
      .last_grant (last_grant),
      .block      (reset_req | reset),
      .gnt        (gnt)
   );

   assign granted   = |gnt;
   assign winner    = gnt[1] ? M1 : M0;
   assign win_write = gnt[1] ? m1_write : m0_write;
   // A simultaneous read and write is handled as a write only.
   assign win_read  = (gnt[1] ? m1_read : m0_read) && !win_write;

   assign m0_waitrequest = !gnt[0];
   assign m1_waitrequest = !gnt[1];
   assign mem_clken      = !reset_req;
   assign mem_reset_req  = reset_req;

   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      if (granted) begin
         mem_chipselect = 1'b1;
         mem_write      = win_write;
         if (gnt[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
         end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= M1;
         rd_pend    <= 1'b0;
         rd_owner   <= M0;
      end else begin
         if (granted) begin
            last_grant <= winner;
         end
         rd_pend <= granted && win_read;
         if (granted && win_read) begin
            rd_owner <= winner;
         end
      end
   end

   assign m0_readdatavalid = rd_pend && (rd_owner == M0);
   assign m1_readdatavalid = rd_pend && (rd_owner == M1);
   assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(m0_read && m0_write))
            else $warning("m0 read and write asserted together; handled as write");
         assert (!(m1_read && m1_write))
            else $warning("m1 read and write asserted together; handled as write");
      end
   end
`endif
endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
// Directed bench with a RAM model and a read-data scoreboard per master.
module tb_nios_system_onchip_memory_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reset_req = 1'b0;
   logic [15:0] m0_address = '0, m1_address = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [15:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q0[$];
   logic [31:0] exp_q1[$];
   logic [31:0] ram [0:255];

   always #5 clk = ~clk;

   nios_system_onchip_memory_arbiter dut (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
   );

   // On-chip RAM model: registered read, byte-lane writes, gated by clken.
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[mem_address[7:0]];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected read data whenever a readdatavalid is seen.
   always @(negedge clk) begin
      if (m0_readdatavalid) begin
         if (exp_q0.size() == 0) chk("m0 unexpected readdatavalid", 32'd1, 32'd0);
         else chk("m0 readdata", m0_readdata, exp_q0.pop_front());
      end else if (!reset) begin
         chk("m0 idle readdata", m0_readdata, 32'h0);
      end
      if (m1_readdatavalid) begin
         if (exp_q1.size() == 0) chk("m1 unexpected readdatavalid", 32'd1, 32'd0);
         else chk("m1 readdata", m1_readdata, exp_q1.pop_front());
      end else if (!reset) begin
         chk("m1 idle readdata", m1_readdata, 32'h0);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m0(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
   endtask

   task automatic idle();
      set_m0(0, 0, 16'h0, 32'h0, 4'h0);
      set_m1(0, 0, 16'h0, 32'h0, 4'h0);
   endtask

   task automatic chk_wait(input string name, input logic w0, input logic w1);
      chk({name, " m0_waitrequest"}, {31'b0, m0_waitrequest}, {31'b0, w0});
      chk({name, " m1_waitrequest"}, {31'b0, m1_waitrequest}, {31'b0, w1});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;

      // Reset: requests present but nothing is granted.
      set_m0(1, 0, 16'h0010, 32'h0, 4'hF);
      @(negedge clk);
      chk_wait("reset", 1'b1, 1'b1);
      chk("reset chipselect", {31'b0, mem_chipselect}, 32'h0);
      chk("reset mem_write", {31'b0, mem_write}, 32'h0);
      chk("reset rdv", {30'b0, m0_readdatavalid, m1_readdatavalid}, 32'h0);
      chk("reset readdata", m0_readdata | m1_readdata, 32'h0);
      next_cycle();
      reset = 1'b0;

      // m0 write then read back.
      set_m0(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      chk_wait("m0 write", 1'b0, 1'b1);
      chk("m0 write mem_write", {31'b0, mem_write}, 32'h1);
      chk("m0 write mem_address", {16'b0, mem_address}, 32'h0010);
      chk("m0 write mem_writedata", mem_writedata, 32'hDEADBEEF);
      next_cycle();
      set_m0(1, 0, 16'h0010, 32'h0, 4'hF);
      exp_q0.push_back(32'hDEADBEEF);
      @(negedge clk);
      chk_wait("m0 read", 1'b0, 1'b1);
      chk("m0 read mem_write", {31'b0, mem_write}, 32'h0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("idle chipselect", {31'b0, mem_chipselect}, 32'h0);
      chk("idle mem_address", {16'b0, mem_address}, 32'h0);
      chk_wait("idle", 1'b1, 1'b1);
      next_cycle();

      // Preload via m1 (last grant ends on m1).
      set_m1(0, 1, 16'h0000, 32'h11111111, 4'hF); next_cycle();
      set_m1(0, 1, 16'h0001, 32'h22222222, 4'hF); next_cycle();
      set_m1(0, 1, 16'h0020, 32'hFFFFFFFF, 4'hF); next_cycle();

      // Continuous contention: strict alternation starting with m0.
      set_m0(1, 0, 16'h0000, 32'h0, 4'hF);
      set_m1(1, 0, 16'h0001, 32'h0, 4'hF);
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) exp_q0.push_back(32'h11111111);
         else exp_q1.push_back(32'h22222222);
         @(negedge clk);
         chk_wait("contention", (k % 2 != 0), (k % 2 == 0));
         next_cycle();
      end
      idle();

      // Partial byte-enable write then read back.
      set_m1(0, 1, 16'h0020, 32'hAAAA5555, 4'h3);
      @(negedge clk);
      chk("be write mem_byteenable", {28'b0, mem_byteenable}, 32'h3);
      next_cycle();
      idle();
      set_m0(1, 0, 16'h0020, 32'h0, 4'hF);
      exp_q0.push_back(32'hFFFF5555);
      next_cycle();
      idle();
      next_cycle();

      // reset_req after an accepted read: data still delivered, m1 stalled.
      set_m0(1, 0, 16'h0010, 32'h0, 4'hF);
      exp_q0.push_back(32'hDEADBEEF);
      next_cycle();
      idle();
      set_m1(1, 0, 16'h0001, 32'h0, 4'hF);
      reset_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_wait("reset_req", 1'b1, 1'b1);
         chk("reset_req clken", {31'b0, mem_clken}, 32'h0);
         chk("reset_req chipselect", {31'b0, mem_chipselect}, 32'h0);
         chk("reset_req passthrough", {31'b0, mem_reset_req}, 32'h1);
         next_cycle();
      end
      reset_req = 1'b0;
      exp_q1.push_back(32'h22222222);
      @(negedge clk);
      chk_wait("reset_req release", 1'b1, 1'b0);
      chk("reset_req release clken", {31'b0, mem_clken}, 32'h1);
      next_cycle();
      idle();
      next_cycle();

      // Reset the cycle after an accepted read: the read is dropped.
      set_m0(1, 0, 16'h0010, 32'h0, 4'hF);
      next_cycle();
      idle();
      reset = 1'b1;
      @(negedge clk);
      chk("mid-read reset rdv", {30'b0, m0_readdatavalid, m1_readdatavalid}, 32'h0);
      chk_wait("mid-read reset", 1'b1, 1'b1);
      chk("mid-read reset chipselect", {31'b0, mem_chipselect}, 32'h0);
      next_cycle();
      reset = 1'b0;
      set_m0(1, 0, 16'h0000, 32'h0, 4'hF);
      set_m1(1, 0, 16'h0001, 32'h0, 4'hF);
      exp_q0.push_back(32'h11111111);
      @(negedge clk);
      chk_wait("post-reset contention", 1'b0, 1'b1);
      next_cycle();
      exp_q1.push_back(32'h22222222);
      @(negedge clk);
      chk_wait("post-reset second", 1'b1, 1'b0);
      next_cycle();
      idle();

      // Read and write together: handled as a write, no read data returned.
      set_m0(1, 1, 16'h0030, 32'h12345678, 4'hF);
      @(negedge clk);
      chk("rw mem_write", {31'b0, mem_write}, 32'h1);
      next_cycle();
      set_m0(1, 0, 16'h0030, 32'h0, 4'hF);
      exp_q0.push_back(32'h12345678);
      next_cycle();
      idle();
      for (int k = 0; k < 3; k++) next_cycle();

      chk("m0 outstanding reads", exp_q0.size(), 32'd0);
      chk("m1 outstanding reads", exp_q1.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
